// File: rtl/ring_pkg.sv
`default_nettype none
// ring_pkg -- message layout shared by the ring router and its bench (rev 1.0).
// Messages are packed {data, src_id, dest_id} with dest_id in the low bits.
package ring_pkg;

    localparam int DEF_PROC_BITS = 4;
    localparam int DEF_DATA_SIZE = 32;
    localparam int DEF_MSG_W     = DEF_DATA_SIZE + 2 * DEF_PROC_BITS;

    localparam int DEST_LSB = 0;
    localparam int SRC_LSB  = DEF_PROC_BITS;
    localparam int DATA_LSB = 2 * DEF_PROC_BITS;

    typedef struct packed {
        logic [DEF_DATA_SIZE-1:0] data;
        logic [DEF_PROC_BITS-1:0] src_id;
        logic [DEF_PROC_BITS-1:0] dest_id;
    } ring_msg_t;

    function automatic int msg_width(input int proc_bits, input int data_size);
        return data_size + 2 * proc_bits;
    endfunction

    function automatic int src_lsb(input int proc_bits);
        return proc_bits;
    endfunction

    function automatic int data_lsb(input int proc_bits);
        return 2 * proc_bits;
    endfunction

endpackage
`default_nettype wire

// File: rtl/msg_fifo.sv
`default_nettype none
// msg_fifo -- show-ahead synchronous FIFO, one per local source (rev 1.0).
// Pointers carry one extra wrap bit so full and empty are distinguishable.
module msg_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic             full,
    output logic             empty,
    output logic [WIDTH-1:0] dout
);
    localparam int AW = $clog2(DEPTH);

    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic [WIDTH-1:0] mem [DEPTH];
    logic             do_push;
    logic             do_pop;

    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign empty   = (wr_ptr == rd_ptr);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign dout    = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    // Storage needs no reset: the pointers alone define what is valid.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= din;
    end

endmodule
`default_nettype wire

// File: rtl/ring_message_router.sv
`default_nettype none
// ring_message_router -- ring node: local delivery, transit forwarding and
// round-robin injection of buffered local requests with a starvation guard (rev 1.0).
module ring_message_router
    import ring_pkg::*;
#(
    parameter int                   PROC_BITS    = 4,
    parameter int                   DATA_SIZE    = 32,
    parameter logic [PROC_BITS-1:0] PROC_ID      = '0,
    parameter int                   NUM_SRC      = 2,
    parameter int                   FIFO_DEPTH   = 4,
    parameter int                   STARVE_LIMIT = 8,
    localparam int                  MSG_W        = msg_width(PROC_BITS, DATA_SIZE)
) (
    input  logic                           clk_in,
    input  logic                           rst_in,
    input  logic [NUM_SRC*DATA_SIZE-1:0]   src_data_in,
    input  logic [NUM_SRC*PROC_BITS-1:0]   src_dest_in,
    input  logic [NUM_SRC-1:0]             src_valid_in,
    output logic [NUM_SRC-1:0]             src_ready_out,
    input  logic [MSG_W-1:0]               ring_msg_in,
    input  logic                           ring_valid_in,
    output logic                           ring_ready_out,
    output logic [MSG_W-1:0]               ring_msg_out,
    output logic                           ring_valid_out,
    input  logic                           ring_ready_in,
    output logic [DATA_SIZE-1:0]           local_data_out,
    output logic [PROC_BITS-1:0]           local_src_out,
    output logic                           local_valid_out,
    input  logic                           local_ready_in
);
    localparam int SRC_OFS  = src_lsb(PROC_BITS);
    localparam int DATA_OFS = data_lsb(PROC_BITS);
    localparam int PTR_W    = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;
    localparam int CNT_W    = (STARVE_LIMIT > 0) ? $clog2(STARVE_LIMIT + 1) : 1;

    logic [NUM_SRC-1:0] fifo_full;
    logic [NUM_SRC-1:0] fifo_empty;
    logic [NUM_SRC-1:0] fifo_push;
    logic [NUM_SRC-1:0] fifo_pop;
    logic [MSG_W-1:0]   fifo_dout [NUM_SRC];

    logic [PTR_W-1:0]   rr_ptr;
    logic [PTR_W-1:0]   rr_next;
    logic [PTR_W-1:0]   inj_idx;
    logic               inj_found;
    int                 cand;
    logic [CNT_W-1:0]   starve_cnt;

    logic hit;
    logic out_free;
    logic local_free;
    logic force_inj;
    logic transit_grant;
    logic take_transit;
    logic do_inject;
    logic hit_xfer;

    for (genvar i = 0; i < NUM_SRC; i++) begin : g_src
        logic [MSG_W-1:0] din;
        assign din = {src_data_in[i*DATA_SIZE +: DATA_SIZE], PROC_ID,
                      src_dest_in[i*PROC_BITS +: PROC_BITS]};
        assign fifo_push[i] = src_valid_in[i] && !fifo_full[i];

        msg_fifo #(
            .WIDTH (MSG_W),
            .DEPTH (FIFO_DEPTH)
        ) u_fifo (
            .clk   (clk_in),
            .rst_n (rst_in),
            .push  (fifo_push[i]),
            .pop   (fifo_pop[i]),
            .din   (din),
            .full  (fifo_full[i]),
            .empty (fifo_empty[i]),
            .dout  (fifo_dout[i])
        );
    end

    assign src_ready_out = ~fifo_full;

    // First non-empty source at or after the round-robin pointer.
    always_comb begin
        inj_found = 1'b0;
        inj_idx   = '0;
        cand      = 0;
        for (int k = 0; k < NUM_SRC; k++) begin
            cand = (int'(rr_ptr) + k) % NUM_SRC;
            if (!inj_found && !fifo_empty[cand]) begin
                inj_found = 1'b1;
                inj_idx   = PTR_W'(cand);
            end
        end
    end

    assign rr_next = (int'(inj_idx) == NUM_SRC - 1) ? '0 : inj_idx + 1'b1;

    assign hit           = (ring_msg_in[DEST_LSB +: PROC_BITS] == PROC_ID);
    assign out_free      = !ring_valid_out || ring_ready_in;
    assign local_free    = !local_valid_out || local_ready_in;
    assign force_inj     = inj_found && (starve_cnt == CNT_W'(STARVE_LIMIT));
    assign transit_grant = !force_inj;
    assign ring_ready_out = hit ? local_free : (out_free && transit_grant);

    assign take_transit = ring_valid_in && !hit && out_free && transit_grant;
    assign do_inject    = out_free && inj_found && !take_transit;
    assign hit_xfer     = ring_valid_in && hit && local_free;

    always_comb begin
        fifo_pop = '0;
        if (do_inject) fifo_pop[inj_idx] = 1'b1;
    end

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            ring_msg_out   <= '0;
            ring_valid_out <= 1'b0;
        end else if (take_transit) begin
            ring_msg_out   <= ring_msg_in;
            ring_valid_out <= 1'b1;
        end else if (do_inject) begin
            ring_msg_out   <= fifo_dout[inj_idx];
            ring_valid_out <= 1'b1;
        end else if (ring_ready_in) begin
            ring_valid_out <= 1'b0;
        end
    end

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            local_data_out  <= '0;
            local_src_out   <= '0;
            local_valid_out <= 1'b0;
        end else if (hit_xfer) begin
            local_data_out  <= ring_msg_in[DATA_OFS +: DATA_SIZE];
            local_src_out   <= ring_msg_in[SRC_OFS +: PROC_BITS];
            local_valid_out <= 1'b1;
        end else if (local_ready_in) begin
            local_valid_out <= 1'b0;
        end
    end

    // Starve count only accumulates while local work is waiting; it cannot
    // exceed the limit because reaching it forces the next slot to injection.
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            rr_ptr     <= '0;
            starve_cnt <= '0;
        end else begin
            if (do_inject) rr_ptr <= rr_next;
            if (do_inject || !inj_found) starve_cnt <= '0;
            else if (take_transit)       starve_cnt <= starve_cnt + 1'b1;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_ring_message_router.sv
`default_nettype none
// tb_ring_message_router -- directed checks of delivery, transit, round robin,
// FIFO backpressure, starvation guard, random stalls and asynchronous reset.
module tb_ring_message_router;
    import ring_pkg::*;

    localparam int PB = DEF_PROC_BITS;
    localparam int DS = DEF_DATA_SIZE;
    localparam int NS = 2;
    localparam int MW = DEF_MSG_W;

    logic            clk = 1'b0;
    logic            rst_n;
    logic [NS*DS-1:0] src_data;
    logic [NS*PB-1:0] src_dest;
    logic [NS-1:0]   src_valid;
    logic [NS-1:0]   src_ready;
    logic [MW-1:0]   rin_msg;
    logic            rin_valid;
    logic            rin_ready;
    logic [MW-1:0]   rout_msg;
    logic            rout_valid;
    logic            rout_ready;
    logic [DS-1:0]   loc_data;
    logic [PB-1:0]   loc_src;
    logic            loc_valid;
    logic            loc_ready;

    int total  = 0;
    int passed = 0;

    logic [MW-1:0]    seen[$];
    logic [MW-1:0]    q[3][$];
    logic [DS+PB-1:0] ql[$];
    logic [MW-1:0]    exp_m;
    logic [DS+PB-1:0] exp_l;
    logic [MW-1:0]    rhold;
    logic [DS+PB-1:0] lhold;
    logic             rstall, lstall, acc_rin;
    logic [NS-1:0]    acc_src;
    int               gen, got, org, lows;
    logic [31:0]      tag;
    logic             rdy [16];
    logic             ov  [16];
    logic [MW-1:0]    om  [16];

    always #5 clk = ~clk;

    ring_message_router #(
        .PROC_BITS    (PB),
        .DATA_SIZE    (DS),
        .PROC_ID      (4'h0),
        .NUM_SRC      (NS),
        .FIFO_DEPTH   (4),
        .STARVE_LIMIT (8)
    ) dut (
        .clk_in          (clk),
        .rst_in          (rst_n),
        .src_data_in     (src_data),
        .src_dest_in     (src_dest),
        .src_valid_in    (src_valid),
        .src_ready_out   (src_ready),
        .ring_msg_in     (rin_msg),
        .ring_valid_in   (rin_valid),
        .ring_ready_out  (rin_ready),
        .ring_msg_out    (rout_msg),
        .ring_valid_out  (rout_valid),
        .ring_ready_in   (rout_ready),
        .local_data_out  (loc_data),
        .local_src_out   (loc_src),
        .local_valid_out (loc_valid),
        .local_ready_in  (loc_ready)
    );

    task automatic chk(input string name, input logic [63:0] obs, input logic [63:0] expv);
        total++;
        assert (obs === expv) passed++;
        else $error("FAIL %s: observed %h required %h", name, obs, expv);
    endtask

    // Record the ring output that transfers at the coming edge, then advance.
    task automatic cyc();
        if (rout_valid && rout_ready) seen.push_back(rout_msg);
        @(posedge clk);
        #1;
    endtask

    initial begin
        src_data = '0; src_dest = '0; src_valid = '0;
        rin_msg = '0; rin_valid = 1'b0; rout_ready = 1'b1; loc_ready = 1'b1;
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_ring_valid", 64'(rout_valid), 64'd0);
        chk("rst_ring_msg", 64'(rout_msg), 64'd0);
        chk("rst_local_valid", 64'(loc_valid), 64'd0);
        chk("rst_local_data", 64'(loc_data), 64'd0);
        chk("rst_local_src", 64'(loc_src), 64'd0);
        rst_n = 1'b1;
        cyc();
        chk("rst_src_ready", 64'(src_ready), 64'h3);

        // Local hit then transit forward.
        rin_msg = {32'hDEADBEEF, 4'd3, 4'd0}; rin_valid = 1'b1;
        #1;
        chk("hit_ready", 64'(rin_ready), 64'd1);
        cyc(); rin_valid = 1'b0;
        chk("hit_valid", 64'(loc_valid), 64'd1);
        chk("hit_data", 64'(loc_data), 64'hDEADBEEF);
        chk("hit_src", 64'(loc_src), 64'd3);
        chk("hit_no_ring", 64'(rout_valid), 64'd0);
        rin_msg = {32'h12345678, 4'd2, 4'd5}; rin_valid = 1'b1;
        cyc(); rin_valid = 1'b0;
        chk("transit_valid", 64'(rout_valid), 64'd1);
        chk("transit_msg", 64'(rout_msg), 64'({32'h12345678, 4'd2, 4'd5}));
        chk("transit_no_local", 64'(loc_valid), 64'd0);
        cyc();

        // Round robin between two loaded sources.
        seen.delete();
        src_dest = {4'd9, 4'd9};
        for (int k = 0; k < 3; k++) begin
            src_valid = 2'b11;
            src_data  = {32'(32'hB000_0000 + k), 32'(32'hA000_0000 + k)};
            cyc();
        end
        src_valid = 2'b00;
        repeat (8) cyc();
        chk("rr_count", 64'(seen.size()), 64'd6);
        for (int k = 0; k < 3; k++) begin
            chk("rr_src0", 64'(seen[2*k]),   64'({32'(32'hA000_0000 + k), 4'd0, 4'd9}));
            chk("rr_src1", 64'(seen[2*k+1]), 64'({32'(32'hB000_0000 + k), 4'd0, 4'd9}));
        end

        // FIFO fill under downstream backpressure.
        seen.delete();
        rout_ready = 1'b0;
        for (int k = 0; k < 5; k++) begin
            src_valid = 2'b01;
            src_data  = {32'h0, 32'(32'hF000_0000 + k)};
            #1;
            chk("full_ready_before", 64'(src_ready[0]), 64'd1);
            cyc();
        end
        src_data = {32'h0, 32'hF000_0005};
        chk("full_ready_after", 64'(src_ready[0]), 64'd0);
        cyc();
        chk("full_still_stalled", 64'(src_ready[0]), 64'd0);
        chk("full_hold_valid", 64'(rout_valid), 64'd1);
        chk("full_hold_msg", 64'(rout_msg), 64'({32'hF000_0000, 4'd0, 4'd9}));
        src_valid = 2'b00;
        rout_ready = 1'b1;
        repeat (8) cyc();
        chk("full_drain_count", 64'(seen.size()), 64'd5);
        for (int k = 0; k < 5; k++)
            chk("full_drain_order", 64'(seen[k]), 64'({32'(32'hF000_0000 + k), 4'd0, 4'd9}));

        // Starvation guard: transit stream with one queued injection.
        tag = 32'h100;
        src_data = {32'hCAFE0001, 32'h0};
        src_dest = {4'd6, 4'd0};
        for (int c = 0; c < 16; c++) begin
            rin_msg = {tag, 4'd4, 4'd7}; rin_valid = 1'b1;
            src_valid = (c == 3) ? 2'b10 : 2'b00;
            #1;
            rdy[c] = rin_ready; ov[c] = rout_valid; om[c] = rout_msg;
            @(posedge clk); #1;
            if (rdy[c]) tag++;
        end
        rin_valid = 1'b0; src_valid = 2'b00;
        lows = 0;
        for (int c = 0; c < 16; c++) if (!rdy[c]) lows++;
        chk("starve_one_stall", 64'(lows), 64'd1);
        chk("starve_stall_cycle", 64'(rdy[12]), 64'd0);
        chk("starve_before", 64'(om[12]), 64'({32'h10B, 4'd4, 4'd7}));
        chk("starve_inj_valid", 64'(ov[13]), 64'd1);
        chk("starve_inj_msg", 64'(om[13]), 64'({32'hCAFE0001, 4'd0, 4'd6}));
        chk("starve_after", 64'(om[14]), 64'({32'h10C, 4'd4, 4'd7}));
        repeat (3) cyc();

        // Random backpressure with scoreboard; data[31:28] tags the origin.
        gen = 0; got = 0; rstall = 1'b0; lstall = 1'b0;
        for (int c = 0; c < 20000 && (gen < 1000 || got < gen); c++) begin
            if (rstall) begin
                chk("bp_ring_hold_valid", 64'(rout_valid), 64'd1);
                chk("bp_ring_hold_msg", 64'(rout_msg), 64'(rhold));
            end
            if (lstall) begin
                chk("bp_local_hold_valid", 64'(loc_valid), 64'd1);
                chk("bp_local_hold", 64'({loc_data, loc_src}), 64'(lhold));
            end
            rout_ready = ($urandom_range(0, 3) != 0);
            loc_ready  = ($urandom_range(0, 3) != 0);
            for (int i = 0; i < NS; i++) begin
                if (!src_valid[i] && gen < 1000 && $urandom_range(0, 2) == 0) begin
                    src_data[i*DS +: DS] = {4'(i), 28'(gen)};
                    src_dest[i*PB +: PB] = 4'($urandom_range(0, 15));
                    src_valid[i] = 1'b1;
                    gen++;
                end
            end
            if (!rin_valid && gen < 1000 && $urandom_range(0, 1) == 0) begin
                if ($urandom_range(0, 1) == 0)
                    rin_msg = {4'h3, 28'(gen), 4'($urandom_range(1, 15)), 4'h0};
                else
                    rin_msg = {4'h2, 28'(gen), 4'($urandom_range(1, 15)), 4'($urandom_range(1, 15))};
                rin_valid = 1'b1;
                gen++;
            end
            #1;
            for (int i = 0; i < NS; i++) begin
                acc_src[i] = src_valid[i] && src_ready[i];
                if (acc_src[i]) q[i].push_back({src_data[i*DS +: DS], 4'h0, src_dest[i*PB +: PB]});
            end
            acc_rin = rin_valid && rin_ready;
            if (acc_rin) begin
                if (rin_msg[PB-1:0] == 4'h0) ql.push_back({rin_msg[MW-1 -: DS], rin_msg[2*PB-1:PB]});
                else q[2].push_back(rin_msg);
            end
            if (rout_valid && rout_ready) begin
                org = int'(rout_msg[MW-1 -: 4]);
                exp_m = 'x;
                if (org < 3 && q[org].size() > 0) exp_m = q[org].pop_front();
                chk("bp_ring_out", 64'(rout_msg), 64'(exp_m));
                got++;
            end
            if (loc_valid && loc_ready) begin
                exp_l = 'x;
                if (ql.size() > 0) exp_l = ql.pop_front();
                chk("bp_local_out", 64'({loc_data, loc_src}), 64'(exp_l));
                got++;
            end
            rstall = rout_valid && !rout_ready; rhold = rout_msg;
            lstall = loc_valid && !loc_ready;   lhold = {loc_data, loc_src};
            @(posedge clk); #1;
            for (int i = 0; i < NS; i++) if (acc_src[i]) src_valid[i] = 1'b0;
            if (acc_rin) rin_valid = 1'b0;
        end
        chk("bp_all_delivered", 64'(got), 64'(gen));
        src_valid = 2'b00; rin_valid = 1'b0;

        // Asynchronous reset in the middle of buffered traffic.
        rout_ready = 1'b0; loc_ready = 1'b0;
        rin_msg = {32'h5555AAAA, 4'd2, 4'd0}; rin_valid = 1'b1;
        cyc(); rin_valid = 1'b0;
        src_valid = 2'b11; src_data = {32'hE1, 32'hE0}; src_dest = {4'd9, 4'd9};
        cyc(); cyc(); src_valid = 2'b00;
        cyc();
        chk("pre_rst_local_valid", 64'(loc_valid), 64'd1);
        chk("pre_rst_ring_valid", 64'(rout_valid), 64'd1);
        #2; rst_n = 1'b0; #1;
        chk("arst_ring_valid", 64'(rout_valid), 64'd0);
        chk("arst_ring_msg", 64'(rout_msg), 64'd0);
        chk("arst_local_valid", 64'(loc_valid), 64'd0);
        chk("arst_local_data", 64'(loc_data), 64'd0);
        chk("arst_local_src", 64'(loc_src), 64'd0);
        repeat (2) @(posedge clk);
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;
        chk("post_rst_src_ready", 64'(src_ready), 64'h3);
        seen.delete();
        rout_ready = 1'b1; loc_ready = 1'b1;
        src_valid = 2'b11; src_data = {32'hF1, 32'hF0};
        cyc(); src_valid = 2'b00;
        repeat (6) cyc();
        chk("post_rst_count", 64'(seen.size()), 64'd2);
        chk("post_rst_first", 64'(seen[0]), 64'({32'hF0, 4'd0, 4'd9}));
        chk("post_rst_second", 64'(seen[1]), 64'({32'hF1, 4'd0, 4'd9}));

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
`default_nettype wire
